// File: rtl/accum_sequencer_pkg.sv
// accum_sequencer_pkg: shared state encodings and sizing helpers for the accumulation sequencer
package accum_sequencer_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_ARM    = 3'd1;
  localparam state_t S_FRAME  = 3'd2;
  localparam state_t S_DRAIN  = 3'd3;
  localparam state_t S_UPLOAD = 3'd4;
  localparam state_t S_DONE   = 3'd5;
  localparam int CHUNK_W = 16;
  function automatic int chunks_per_frame(input int frame_points, input int upload_points);
    return frame_points / upload_points;
  endfunction
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/accum_sequencer_upload_pacer.sv
// accum_sequencer_upload_pacer: chunk counter, inter-chunk gap timer and upload_trigger strobe
// en_i enables pacing (UPLOAD state), clr_i clears chunk_cnt_o on a new acquisition,
// done_o reports all chunks issued, gap expired and no buffer data left.
module accum_sequencer_upload_pacer
  import accum_sequencer_pkg::*;
#(
  parameter int FRAME_POINTS       = 16384,
  parameter int UPLOAD_POINTS_ONCE = 512,
  parameter int UPLOAD_GAP         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic               upload_en_i,
  input  logic               upload_req_i,
  output logic               trigger_o,
  output logic [CHUNK_W-1:0] chunk_cnt_o,
  output logic               done_o
);
  localparam logic [CHUNK_W-1:0] CHUNKS = CHUNK_W'(chunks_per_frame(FRAME_POINTS, UPLOAD_POINTS_ONCE));
  localparam int GW = cnt_w(UPLOAD_POINTS_ONCE + UPLOAD_GAP);
  // strobes land exactly UPLOAD_POINTS_ONCE+UPLOAD_GAP cycles apart: the firing cycle counts as one
  localparam logic [GW-1:0] GAP_LOAD = GW'(UPLOAD_POINTS_ONCE + UPLOAD_GAP - 1);
  logic [CHUNK_W-1:0] chunk_q;
  logic [GW-1:0] gap_q;
  logic trig_q, fire, expired;
  assign expired = gap_q == '0;
  assign fire = en_i && upload_en_i && upload_req_i && expired && (chunk_q < CHUNKS);
  assign done_o = en_i && (chunk_q == CHUNKS) && expired && !upload_en_i;
  assign trigger_o = trig_q;
  assign chunk_cnt_o = chunk_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q  <= 1'b0;
      chunk_q <= '0;
      gap_q   <= '0;
    end else begin
      trig_q  <= fire;
      chunk_q <= clr_i ? '0 : fire ? chunk_q + CHUNK_W'(1) : chunk_q;
      gap_q   <= !en_i ? '0 : fire ? GAP_LOAD : expired ? gap_q : gap_q - GW'(1);
    end
  end
endmodule

// File: rtl/accum_sequencer.sv
// accum_sequencer: sequences pulse accumulation, drain and paced upload of the spectrum FIFO buffer
// Inputs: start/abort commands, pls_num, trigger_start (level), valid_in, upload_en_in, upload_req.
// Outputs: Buffer_En, is_first_pls, upload_trigger, fifo_flush, busy, acq_done, overrun, pls_cnt, chunk_cnt.
module accum_sequencer
  import accum_sequencer_pkg::*;
#(
  parameter int FRAME_POINTS       = 16384,
  parameter int UPLOAD_POINTS_ONCE = 512,
  parameter int PLS_W              = 16,
  parameter int DRAIN_CYCLES       = 8,
  parameter int UPLOAD_GAP         = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [PLS_W-1:0]   pls_num,
  input  logic               trigger_start,
  input  logic               valid_in,
  input  logic               upload_en_in,
  input  logic               upload_req,
  output logic               Buffer_En,
  output logic               is_first_pls,
  output logic               upload_trigger,
  output logic               fifo_flush,
  output logic               busy,
  output logic               acq_done,
  output logic               overrun,
  output logic [PLS_W-1:0]   pls_cnt,
  output logic [CHUNK_W-1:0] chunk_cnt
);
  localparam int SW = cnt_w(FRAME_POINTS);
  localparam int DW = cnt_w(DRAIN_CYCLES);
  localparam logic [SW-1:0] SAMP_LAST  = SW'(FRAME_POINTS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  state_t state_q, state_d;
  logic [PLS_W-1:0] n_q, n_d, pls_q, pls_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [DW-1:0] drain_q, drain_d;
  logic buf_en_q, buf_en_d, first_q, first_d, flush_q, flush_d;
  logic done_q, done_d, ovr_q, ovr_d, trig_q, edge_q;
  logic go, frame_end, last_pls, up_done;
  assign go = (state_q == S_IDLE) && start && !abort;
  assign frame_end = (state_q == S_FRAME) && valid_in && (samp_q == SAMP_LAST);
  // widened so n_q = all-ones cannot wrap the comparison
  assign last_pls = ({1'b0, pls_q} + (PLS_W+1)'(1)) == {1'b0, n_q};
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    pls_d    = pls_q;
    samp_d   = samp_q;
    drain_d  = '0;
    buf_en_d = buf_en_q;
    first_d  = first_q;
    flush_d  = 1'b0;
    done_d   = 1'b0;
    ovr_d    = ovr_q;
    if (abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      buf_en_d = 1'b0;
      first_d  = 1'b0;
      flush_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (go) begin
          state_d  = S_ARM;
          n_d      = (pls_num == '0) ? PLS_W'(1) : pls_num;
          pls_d    = '0;
          ovr_d    = 1'b0;
          buf_en_d = 1'b1;
          first_d  = 1'b1;
        end
        S_ARM: if (edge_q) begin
          state_d = S_FRAME;
          samp_d  = '0;
        end
        S_FRAME: begin
          ovr_d  = ovr_q | edge_q;
          samp_d = valid_in ? samp_q + SW'(1) : samp_q;
          if (frame_end) begin
            pls_d   = (&pls_q) ? pls_q : pls_q + PLS_W'(1);
            first_d = 1'b0;
            state_d = last_pls ? S_DRAIN : S_ARM;
          end
        end
        S_DRAIN: begin
          drain_d = drain_q + DW'(1);
          if (drain_q == DRAIN_LAST) begin
            buf_en_d = 1'b0;
            state_d  = S_UPLOAD;
          end
        end
        S_UPLOAD: if (up_done) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      pls_q    <= '0;
      samp_q   <= '0;
      drain_q  <= '0;
      buf_en_q <= 1'b0;
      first_q  <= 1'b0;
      flush_q  <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      trig_q   <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      pls_q    <= pls_d;
      samp_q   <= samp_d;
      drain_q  <= drain_d;
      buf_en_q <= buf_en_d;
      first_q  <= first_d;
      flush_q  <= flush_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      trig_q   <= trigger_start;
      edge_q   <= trigger_start & ~trig_q;
    end
  end
  accum_sequencer_upload_pacer #(
    .FRAME_POINTS(FRAME_POINTS),
    .UPLOAD_POINTS_ONCE(UPLOAD_POINTS_ONCE),
    .UPLOAD_GAP(UPLOAD_GAP)
  ) u_pacer (
    .clk(clk),
    .rst_n(rst_n),
    .en_i(state_q == S_UPLOAD),
    .clr_i(go),
    .upload_en_i(upload_en_in),
    .upload_req_i(upload_req),
    .trigger_o(upload_trigger),
    .chunk_cnt_o(chunk_cnt),
    .done_o(up_done)
  );
  assign Buffer_En    = buf_en_q;
  assign is_first_pls = first_q;
  assign fifo_flush   = flush_q;
  assign busy         = state_q != S_IDLE;
  assign acq_done     = done_q;
  assign overrun      = ovr_q;
  assign pls_cnt      = pls_q;
endmodule

// File: tb/tb_accum_sequencer.sv
// tb_accum_sequencer: directed table-driven and hand-sequenced checks of accum_sequencer
module tb_accum_sequencer;
  localparam int FP = 16, UP = 4, DC = 8, UG = 4, PW = 16;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic trigger_start = 1'b0, valid_in = 1'b0, upload_en_in = 1'b0, upload_req = 1'b0;
  logic [PW-1:0] pls_num = '0;
  logic Buffer_En, is_first_pls, upload_trigger, fifo_flush, busy, acq_done, overrun;
  logic [PW-1:0] pls_cnt;
  logic [15:0] chunk_cnt;
  int checks = 0, errors = 0;
  typedef struct {
    logic [PW-1:0] pls;
    bit gapped;
    int req_delay;
    int exp_pls;
  } vec_t;
  vec_t tbl[4];
  always #5 clk = ~clk;
  accum_sequencer #(
    .FRAME_POINTS(FP), .UPLOAD_POINTS_ONCE(UP), .PLS_W(PW), .DRAIN_CYCLES(DC), .UPLOAD_GAP(UG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pls_num(pls_num),
    .trigger_start(trigger_start), .valid_in(valid_in), .upload_en_in(upload_en_in),
    .upload_req(upload_req), .Buffer_En(Buffer_En), .is_first_pls(is_first_pls),
    .upload_trigger(upload_trigger), .fifo_flush(fifo_flush), .busy(busy),
    .acq_done(acq_done), .overrun(overrun), .pls_cnt(pls_cnt), .chunk_cnt(chunk_cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic trig();
    trigger_start = 1'b1;
    tick(1);
    trigger_start = 1'b0;
    tick(1);
  endtask
  task automatic send_n(input int n, input bit gapped);
    for (int i = 0; i < n; i++) begin
      if (gapped) begin
        valid_in = 1'b0;
        tick(1);
      end
      valid_in = 1'b1;
      tick(1);
    end
    valid_in = 1'b0;
  endtask
  task automatic begin_acq(input logic [PW-1:0] n);
    pls_num = n;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, " Buffer_En"}, Buffer_En, 0);
    chk({tag, " is_first_pls"}, is_first_pls, 0);
    chk({tag, " upload_trigger"}, upload_trigger, 0);
    chk({tag, " fifo_flush"}, fifo_flush, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " acq_done"}, acq_done, 0);
    chk({tag, " overrun"}, overrun, 0);
    chk({tag, " pls_cnt"}, pls_cnt, 0);
    chk({tag, " chunk_cnt"}, chunk_cnt, 0);
  endtask
  task automatic run_acq(input vec_t v, input int r);
    int prev_pos, ntrig, ndone;
    begin_acq(v.pls);
    chk($sformatf("r%0d start Buffer_En", r), Buffer_En, 1);
    chk($sformatf("r%0d start is_first_pls", r), is_first_pls, 1);
    chk($sformatf("r%0d start busy", r), busy, 1);
    chk($sformatf("r%0d start pls_cnt", r), pls_cnt, 0);
    chk($sformatf("r%0d start chunk_cnt", r), chunk_cnt, 0);
    valid_in = 1'b1;
    tick(3);
    valid_in = 1'b0;
    for (int p = 0; p < v.exp_pls; p++) begin
      trig();
      chk($sformatf("r%0d p%0d first before", r, p), is_first_pls, (p == 0));
      send_n(FP - 1, v.gapped);
      chk($sformatf("r%0d p%0d pls_cnt before last sample", r, p), pls_cnt, p);
      send_n(1, v.gapped);
      chk($sformatf("r%0d p%0d pls_cnt after frame", r, p), pls_cnt, p + 1);
      chk($sformatf("r%0d p%0d first after", r, p), is_first_pls, 0);
      chk($sformatf("r%0d p%0d Buffer_En after frame", r, p), Buffer_En, 1);
    end
    upload_en_in = 1'b1;
    upload_req = 1'b0;
    tick(DC - 1);
    chk($sformatf("r%0d Buffer_En drain end", r), Buffer_En, 1);
    tick(1);
    chk($sformatf("r%0d Buffer_En output mode", r), Buffer_En, 0);
    ntrig = 0;
    ndone = 0;
    prev_pos = -1;
    for (int c = 0; c < 50; c++) begin
      upload_req = (c >= v.req_delay);
      tick(1);
      if (upload_trigger) begin
        if (ntrig == 0) chk($sformatf("r%0d first trigger cycle", r), c, v.req_delay);
        else chk($sformatf("r%0d trigger spacing", r), c - prev_pos, UP + UG);
        prev_pos = c;
        ntrig++;
        if (ntrig == FP / UP) upload_en_in = 1'b0;
      end
      if (acq_done) ndone++;
    end
    upload_req = 1'b0;
    upload_en_in = 1'b0;
    chk($sformatf("r%0d trigger count", r), ntrig, FP / UP);
    chk($sformatf("r%0d acq_done count", r), ndone, 1);
    chk($sformatf("r%0d busy end", r), busy, 0);
    chk($sformatf("r%0d chunk_cnt end", r), chunk_cnt, FP / UP);
    chk($sformatf("r%0d pls_cnt end", r), pls_cnt, v.exp_pls);
    chk($sformatf("r%0d Buffer_En end", r), Buffer_En, 0);
  endtask
  initial begin
    tbl[0] = '{pls: 16'd0, gapped: 1'b1, req_delay: 2, exp_pls: 1};
    tbl[1] = '{pls: 16'd3, gapped: 1'b0, req_delay: 0, exp_pls: 3};
    tbl[2] = '{pls: 16'd2, gapped: 1'b1, req_delay: 3, exp_pls: 2};
    tbl[3] = '{pls: 16'd1, gapped: 1'b0, req_delay: 1, exp_pls: 1};
    tick(2);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(1);
    begin_acq(16'd1);
    trig();
    send_n(FP / 2, 1'b0);
    chk("ovr before", overrun, 0);
    trig();
    chk("ovr set", overrun, 1);
    chk("ovr pls_cnt mid", pls_cnt, 0);
    send_n(FP / 2, 1'b0);
    chk("ovr pls_cnt done", pls_cnt, 1);
    chk("ovr sticky", overrun, 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("ovr abort flush", fifo_flush, 1);
    chk("ovr abort busy", busy, 0);
    chk("ovr held after abort", overrun, 1);
    pls_num = 16'd2;
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    chk("idle abort+start busy", busy, 0);
    chk("idle abort+start flush", fifo_flush, 0);
    begin_acq(16'd3);
    chk("restart ovr cleared", overrun, 0);
    trig();
    send_n(FP, 1'b0);
    chk("abort seq pls1", pls_cnt, 1);
    pls_num = 16'd9;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy start ignored pls", pls_cnt, 1);
    chk("busy start ignored first", is_first_pls, 0);
    trig();
    send_n(5, 1'b0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort Buffer_En", Buffer_En, 0);
    chk("abort first", is_first_pls, 0);
    chk("abort flush", fifo_flush, 1);
    chk("abort acq_done", acq_done, 0);
    chk("abort pls held", pls_cnt, 1);
    tick(1);
    chk("abort flush one cycle", fifo_flush, 0);
    chk("abort no done", acq_done, 0);
    for (int r = 0; r < 4; r++) run_acq(tbl[r], r);
    begin_acq(16'd1);
    trig();
    send_n(FP, 1'b0);
    upload_en_in = 1'b1;
    upload_req = 1'b1;
    tick(DC);
    chk("rst seq output mode", Buffer_En, 0);
    tick(1);
    chk("rst seq trigger", upload_trigger, 1);
    chk("rst seq chunk", chunk_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    upload_en_in = 1'b0;
    upload_req = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(2);
    chk("post reset busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
